// File: rtl/bitser_seq.sv
// Bit-serial instruction sequencer: accepts one 16-bit instruction and steps the datapath one bit per cycle.
// Latency: ALU ops take 11 cycles accept-to-accept (DECODE, 8x EXEC, WB); OUT takes 3; NOP and reserved take 2.
// Backpressure: instr_ready is high only in IDLE; instr_valid while busy or halted is dropped, not queued.
module bitser_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [3:0]  opcode,
  input  logic [11:0] operand,
  output logic        instr_ready,
  output logic        shift_en,
  output logic [2:0]  bit_idx,
  output logic [2:0]  alu_op,
  output logic [1:0]  rs_sel,
  output logic [1:0]  rd_sel,
  output logic        imm_bit,
  output logic        carry_init,
  output logic        wb_en,
  output logic        out_load,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [7:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_OUT  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t      state;
  logic [3:0]  op_q;
  logic [11:0] opd_q;
  logic [7:0]  imm8;

  // Immediate field of the latched instruction; used bit by bit during EXEC.
  assign imm8 = opd_q[11:4];

  // Sequencer FSM; every output is a flop updated together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= 4'd0;
      opd_q       <= 12'd0;
      instr_ready <= 1'b1;
      shift_en    <= 1'b0;
      bit_idx     <= 3'd0;
      alu_op      <= 3'd0;
      rs_sel      <= 2'd0;
      rd_sel      <= 2'd0;
      imm_bit     <= 1'b0;
      carry_init  <= 1'b0;
      wb_en       <= 1'b0;
      out_load    <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      retired     <= 8'd0;
    end else begin
      // Commit strobes are single-cycle unless re-armed below.
      wb_en    <= 1'b0;
      out_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            op_q        <= opcode;
            opd_q       <= operand;
            state       <= S_DECODE;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_DECODE: begin
          if (op_q >= 4'd1 && op_q <= OP_MOV) begin
            // MOV reuses PASS_RS (0); ADD..LDI map straight onto alu_op 1..6.
            alu_op     <= (op_q == OP_MOV) ? 3'd0 : op_q[2:0];
            rs_sel     <= opd_q[3:2];
            rd_sel     <= opd_q[1:0];
            bit_idx    <= 3'd0;
            shift_en   <= 1'b1;
            imm_bit    <= opd_q[4];
            carry_init <= (op_q == OP_SUB);
            state      <= S_EXEC;
          end else if (op_q == OP_OUT) begin
            // OUT needs no shifting: point rd at the register to copy and commit.
            rd_sel   <= opd_q[1:0];
            out_load <= 1'b1;
            state    <= S_WB;
          end else if (op_q == OP_HALT) begin
            busy   <= 1'b0;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            // NOP and reserved opcodes retire immediately; reserved ones flag illegal.
            if (op_q != OP_NOP) illegal <= 1'b1;
            retired     <= retired + 8'd1;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_EXEC: begin
          if (bit_idx == 3'd7) begin
            shift_en   <= 1'b0;
            imm_bit    <= 1'b0;
            carry_init <= 1'b0;
            bit_idx    <= 3'd0;
            wb_en      <= 1'b1;
            state      <= S_WB;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            imm_bit <= imm8[bit_idx + 3'd1];
          end
        end
        S_WB: begin
          retired     <= retired + 8'd1;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bitser_seq.md
BITSER_SEQ -- requirements
Module: bitser_seq

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-003 instr_valid  in  1  one-cycle pulse: complete instruction present on opcode/operand.
REQ-004 opcode  in  4  instruction opcode.
REQ-005 operand  in  12  fields: rd=operand[1:0], rs=operand[3:2], imm8=operand[11:4].
REQ-006 instr_ready  out  1  high only in IDLE; instruction accepted when instr_valid and instr_ready.
REQ-007 shift_en  out  1  datapath shift-register enable, one bit per cycle.
REQ-008 bit_idx  out  3  current bit position, LSB first.
REQ-009 alu_op  out  3  0 PASS_RS, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 PASS_IMM, 7 unused.
REQ-010 rs_sel, rd_sel  out  2 each  register-file source and destination selects.
REQ-011 imm_bit  out  1  imm8[bit_idx] during EXEC, else 0.
REQ-012 carry_init  out  1  carry flop preset value, valid when bit_idx==0 in EXEC.
REQ-013 wb_en  out  1  one-cycle pulse: commit shifted result to rd.
REQ-014 out_load  out  1  one-cycle pulse: copy register rd to the LED output register.
REQ-015 busy, halted, illegal  out  1 each  status flags.
REQ-016 retired  out  8  count of completed instructions.

Function
REQ-017 FSM states SHALL be IDLE, DECODE, EXEC, WB, HALT.
REQ-018 IDLE: on accepted instruction, latch opcode/operand and go to DECODE; later input changes SHALL NOT affect the instruction in flight.
REQ-019 instr_valid outside IDLE SHALL be ignored (dropped, not queued).
REQ-020 Opcode map: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LDI, 7 MOV, 8 OUT, 9-14 reserved, 15 HALT.
REQ-021 DECODE, opcodes 1-7: drive alu_op (ADD..XOR = 1..5, LDI = 6, MOV = 0), rs_sel, rd_sel; go to EXEC with bit_idx=0.
REQ-022 EXEC: shift_en=1 for exactly 8 consecutive cycles, bit_idx 0..7; after bit_idx==7 go to WB.
REQ-023 carry_init=1 for SUB, 0 otherwise.
REQ-024 WB: wb_en=1 for one cycle for opcodes 1-7; out_load=1 for one cycle for opcode 8; then IDLE.
REQ-025 DECODE opcode 8 SHALL go directly to WB (no EXEC cycles).
REQ-026 DECODE opcode 0 SHALL return directly to IDLE; no wb_en, no out_load.
REQ-027 DECODE opcodes 9-14 SHALL behave as NOP and set illegal sticky until rst.
REQ-028 DECODE opcode 15 SHALL enter HALT; HALT is exited only by rst.
REQ-029 Latency: accept at edge T -> DECODE T+1, EXEC T+2..T+9, WB T+10, instr_ready high again at T+11 (ALU ops: 11 cycles accept-to-accept).
REQ-030 busy=1 in DECODE, EXEC, WB; halted=1 only in HALT; instr_ready=0 in HALT.
REQ-031 retired SHALL increment by 1 on leaving WB, or on DECODE->IDLE for NOP/reserved; HALT SHALL NOT count; 255 wraps to 0.
REQ-032 shift_en, wb_en, out_load, imm_bit, carry_init SHALL be 0 in every state where not explicitly asserted.

Reset
REQ-033 rst asserted at any edge, including mid-EXEC or in HALT: next state IDLE; no wb_en or out_load pulse issued for the aborted instruction.
REQ-034 Reset values: instr_ready=1, all other outputs 0 (bit_idx=0, alu_op=0, selects=0, retired=0, illegal=0, halted=0).
REQ-035 rst has priority over instr_valid in the same cycle.

Verification
REQ-036 ADD, operand=0x009 (rs=2, rd=1), single instr_valid -> shift_en high 8 cycles, bit_idx 0..7, alu_op=1, carry_init=0, wb_en one pulse at T+10, retired=1.
REQ-037 LDI, operand=0xA50 (imm8=0xA5, rd=0) -> imm_bit sequence 1,0,1,0,0,1,0,1 over bit_idx 0..7, alu_op=6, wb_en at T+10.
REQ-038 SUB accepted, instr_valid re-pulsed with ADD at T+4 -> second instruction ignored; carry_init=1 in EXEC; only one wb_en; retired=1.
REQ-039 Opcode 12, then OUT with rd=3 -> illegal=1 and stays 1; OUT gives out_load one pulse, zero shift_en cycles; retired=2.
REQ-040 256 NOPs from reset -> retired wraps to 0; no wb_en/out_load ever seen.
REQ-041 HALT, then ADD pulses -> halted=1, instr_ready=0, no response; rst at bit_idx=4 of a prior ADD -> IDLE next cycle, no wb_en, all outputs at reset values.
